// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg
// Shared definitions for the logic_unit_pipe slice: operation encoding,
// flag bit positions and field widths.
package logic_unit_pkg;

  localparam int LU_OP_W   = 3;
  localparam int LU_FLAG_W = 3;

  // Bit positions inside out_flags.
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_ONES = 1;
  localparam int FLAG_PAR  = 2;

  typedef enum logic [LU_OP_W-1:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_NOT_A  = 3'd2,
    OP_XOR    = 3'd3,
    OP_NAND   = 3'd4,
    OP_NOR    = 3'd5,
    OP_XNOR   = 3'd6,
    OP_PASS_B = 3'd7
  } lu_op_e;

endpackage

// File: rtl/lu_pipe_reg.sv
// lu_pipe_reg
// Generic one-entry valid/ready pipeline register.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Ready never depends on the valid of the same interface, and a
// stalled entry (o_valid && !i_ready) keeps o_data stable until taken.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_valid       upstream data valid
//   o_ready       this stage can take data this cycle
//   i_data        upstream payload (DATA_W bits)
//   o_valid       stage holds a valid entry
//   i_ready       downstream takes the entry this cycle
//   o_data        held payload (DATA_W bits)
module lu_pipe_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              w_load;

  // Empty, or the current entry leaves this same edge.
  assign w_load  = !r_valid || i_ready;
  assign o_ready = w_load;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= i_valid;
      // Payload only moves with a real transfer, so a bubble keeps old data.
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
// Two-stage pipelined bitwise logic unit. Stage 1 registers the selected
// operation result; stage 2 registers that result together with its zero,
// all-ones and parity flags. A saturating counter tracks completed output
// handshakes.
//
// Handshake: transfers occur on rising edges where valid && ready. in_ready
// is derived only from the stage valid bits and out_ready, never in_valid.
// While out_valid && !out_ready, out_result and out_flags hold.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         input handshake
//   in_a, in_b (WIDTH)        operands
//   in_op (3)                 operation select (lu_op_e)
//   out_valid/out_ready       output handshake
//   out_result (WIDTH)        result
//   out_flags (3)             {parity, all-ones, zero}
//   cnt_clr                   synchronous clear of txn_count (wins over count)
//   txn_count (CNT_W)         saturating count of output handshakes
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [LU_OP_W-1:0] in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [LU_FLAG_W-1:0] out_flags,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   txn_count
);

  localparam int S2_W = WIDTH + LU_FLAG_W;

  logic [WIDTH-1:0]     w_op_res;
  logic                 w_s1_valid;
  logic [WIDTH-1:0]     w_s1_data;
  logic                 w_s2_ready;
  logic [LU_FLAG_W-1:0] w_flags;
  logic [S2_W-1:0]      w_s2_in;
  logic [S2_W-1:0]      w_s2_data;
  logic                 w_out_hs;
  logic [CNT_W-1:0]     r_cnt;

  // Operation mux.
  always_comb begin
    w_op_res = '0;
    case (lu_op_e'(in_op))
      OP_AND:    w_op_res = in_a & in_b;
      OP_OR:     w_op_res = in_a | in_b;
      OP_NOT_A:  w_op_res = ~in_a;
      OP_XOR:    w_op_res = in_a ^ in_b;
      OP_NAND:   w_op_res = ~(in_a & in_b);
      OP_NOR:    w_op_res = ~(in_a | in_b);
      OP_XNOR:   w_op_res = ~(in_a ^ in_b);
      OP_PASS_B: w_op_res = in_b;
      default:   w_op_res = '0;
    endcase
  end

  lu_pipe_reg #(.DATA_W(WIDTH)) u_stage1 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_op_res),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_ready),
    .o_data  (w_s1_data)
  );

  // Flags are computed between the stages so they register alongside the
  // result they describe.
  always_comb begin
    w_flags            = '0;
    w_flags[FLAG_ZERO] = (w_s1_data == '0);
    w_flags[FLAG_ONES] = &w_s1_data;
    w_flags[FLAG_PAR]  = ^w_s1_data;
  end

  assign w_s2_in = {w_flags, w_s1_data};

  lu_pipe_reg #(.DATA_W(S2_W)) u_stage2 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_ready),
    .i_data  (w_s2_in),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_s2_data)
  );

  assign out_result = w_s2_data[WIDTH-1:0];
  assign out_flags  = w_s2_data[WIDTH +: LU_FLAG_W];

  assign w_out_hs = out_valid && out_ready;

  // Saturating transaction counter; clear takes priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_out_hs && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign txn_count = r_cnt;

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic         cnt_clr   = 1'b0;
  logic [W-1:0] in_a      = '0;
  logic [W-1:0] in_b      = '0;
  logic [2:0]   in_op     = '0;

  logic         in_ready,   in_ready_2;
  logic         out_valid,  out_valid_2;
  logic [W-1:0] out_result, out_result_2;
  logic [2:0]   out_flags,  out_flags_2;
  logic [15:0]  txn_count;
  logic [1:0]   txn_count_2;

  logic_unit_pipe #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .cnt_clr(cnt_clr), .txn_count(txn_count)
  );

  // Same stimulus, narrow counter to exercise saturation.
  logic_unit_pipe #(.WIDTH(W), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_2),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid_2), .out_ready(out_ready),
    .out_result(out_result_2), .out_flags(out_flags_2),
    .cnt_clr(cnt_clr), .txn_count(txn_count_2)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: operation from the op table.
  function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~a;
      3'd3:    return a ^ b;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return ~(a ^ b);
      default: return b;
    endcase
  endfunction

  // Reference flags from a population count of the result.
  function automatic logic [2:0] ref_flags(input logic [W-1:0] r);
    int p;
    p = 0;
    for (int i = 0; i < W; i++) p += int'(r[i]);
    return {(p % 2) == 1, p == W, p == 0};
  endfunction

  // Pipeline model: FIFO of capacity 2; an entry is visible at the output
  // once at least one edge has passed since the edge that accepted it.
  logic [W-1:0] exp_q[$];
  logic [2:0]   expf_q[$];
  int           acc_q[$];
  int           edge_n = 0;
  int           cnt16  = 0;
  int           cnt2   = 0;
  bit           m_vis, m_pop, m_push;
  logic [W-1:0] m_r;
  bit           run_cmp = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      expf_q.delete();
      acc_q.delete();
      cnt16 = 0;
      cnt2  = 0;
    end else begin
      m_vis  = (exp_q.size() > 0) && (acc_q[0] < edge_n);
      m_pop  = m_vis && out_ready;
      m_push = in_valid && ((exp_q.size() < 2) || out_ready);
      edge_n++;
      if (m_pop) begin
        void'(exp_q.pop_front());
        void'(expf_q.pop_front());
        void'(acc_q.pop_front());
      end
      if (m_push) begin
        m_r = ref_result(in_a, in_b, in_op);
        exp_q.push_back(m_r);
        expf_q.push_back(ref_flags(m_r));
        acc_q.push_back(edge_n);
      end
      if (cnt_clr) begin
        cnt16 = 0;
        cnt2  = 0;
      end else if (m_pop) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt2 < 3) cnt2++;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  bit c_vis;
  bit c_rdy;
  always @(negedge clk) begin
    if (run_cmp && !rst) begin
      c_vis = (exp_q.size() > 0) && (acc_q[0] < edge_n);
      c_rdy = (exp_q.size() < 2) || out_ready;
      check("out_valid", out_valid, c_vis);
      check("out_valid_2", out_valid_2, c_vis);
      check("in_ready", in_ready, c_rdy);
      check("in_ready_2", in_ready_2, c_rdy);
      if (c_vis) begin
        check("out_result", out_result, exp_q[0]);
        check("out_flags", out_flags, expf_q[0]);
        check("out_result_2", out_result_2, exp_q[0]);
        check("out_flags_2", out_flags_2, expf_q[0]);
      end
      check("txn_count", txn_count, cnt16);
      check("txn_count_2", txn_count_2, cnt2);
    end
  end

  // ---------------- driver tasks ----------------
  // Single transaction with out_ready high; checks latency and literal values.
  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, input logic [W-1:0] er, input logic [2:0] ef);
    int n;
    @(negedge clk); #1;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 6) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, "_lat"}, n, 2);
    check({name, "_res"}, out_result, er);
    check({name, "_flg"}, out_flags, ef);
  endtask

  task automatic clear_count();
    @(negedge clk); #1 cnt_clr = 1'b1;
    @(negedge clk); #1 cnt_clr = 1'b0;
  endtask

  task automatic stall_test();
    @(negedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd7; in_a = 8'h5A; in_b = 8'h11;
    #1 check("stall_rdy0", in_ready, 1);
    @(negedge clk); #1 in_b = 8'h22;
    #1 check("stall_rdy1", in_ready, 1);
    @(negedge clk); #1 in_b = 8'h33;
    #1 check("stall_rdy2", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("stall_hold", out_result, 8'h11);
      check("stall_full", in_ready, 0);
    end
    out_ready = 1'b1;
    #1 check("drain0", out_result, 8'h11);
    check("drain_rdy", in_ready, 1);
    @(negedge clk); #1 in_valid = 1'b0;
    check("drain1", out_result, 8'h22);
    @(negedge clk); #1;
    check("drain2", out_result, 8'h33);
    check("drain2_v", out_valid, 1);
    @(negedge clk); #1;
    check("drain_empty", out_valid, 0);
  endtask

  task automatic stream_test();
    int cnt, first, last;
    cnt = 0; first = -1; last = -1;
    clear_count();
    out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk); #1;
      if (c < 10) begin
        in_valid = 1'b1;
        in_a  = 8'($urandom);
        in_b  = 8'($urandom);
        in_op = 3'($urandom_range(0, 7));
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
      end
    end
    check("stream_cnt", cnt, 10);
    check("stream_span", last - first, 9);
    check("stream_txn", txn_count, 10);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", out_result, 0);
    check("rst_flags", out_flags, 0);
    check("rst_count", txn_count, 0);
    @(negedge clk); #1 rst = 1'b0;
    run_cmp = 1'b1;

    directed("and",  8'hF0, 8'hCC, 3'd0, 8'hC0, 3'b000);
    // 3C has four set bits, so parity is 0.
    directed("xor",  8'hF0, 8'hCC, 3'd3, 8'h3C, 3'b000);
    directed("nota", 8'hFF, 8'($urandom), 3'd2, 8'h00, 3'b001);
    directed("nor",  8'h00, 8'h00, 3'd5, 8'hFF, 3'b010);
    directed("passb", 8'($urandom), 8'h01, 3'd7, 8'h01, 3'b100);
    directed("nand", 8'hFF, 8'h0F, 3'd4, 8'hF0, 3'b000);
    directed("xnor", 8'hA5, 8'hA4, 3'd6, 8'hFE, 3'b100);

    stall_test();
    stream_test();

    // Saturation of the narrow counter, then clear coincident with a handshake.
    clear_count();
    for (int i = 0; i < 5; i++) directed("sat", 8'h00, 8'(i + 1), 3'd7, 8'(i + 1), ref_flags(8'(i + 1)));
    @(negedge clk); #1;
    check("sat_cnt2", txn_count_2, 3);
    check("sat_cnt16", txn_count, 5);
    directed("clrhs", 8'h0F, 8'h00, 3'd1, 8'h0F, 3'b000);
    cnt_clr = 1'b1;
    @(negedge clk); #1 cnt_clr = 1'b0;
    check("clr_cnt16", txn_count, 0);
    check("clr_cnt2", txn_count_2, 0);

    // Reset with both stages full.
    directed("prerst", 8'h12, 8'h34, 3'd7, 8'h34, 3'b100);
    @(negedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd0; in_a = 8'hFF; in_b = 8'h0F;
    @(negedge clk); #1 in_b = 8'hF0;
    @(negedge clk); #1 in_valid = 1'b0;
    check("full_v", out_valid, 1);
    check("full_rdy", in_ready, 0);
    check("full_cnt", txn_count, 1);
    rst = 1'b1;
    #1;
    check("midrst_v", out_valid, 0);
    check("midrst_cnt", txn_count, 0);
    check("midrst_cnt2", txn_count_2, 0);
    check("midrst_rdy", in_ready, 1);
    @(negedge clk); #1 rst = 1'b0;
    directed("postrst", 8'hAA, 8'h55, 3'd1, 8'hFF, 3'b010);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      cnt_clr   = ($urandom_range(0, 39) == 0);
      in_a  = 8'($urandom);
      in_b  = 8'($urandom);
      in_op = 3'($urandom_range(0, 7));
    end
    @(negedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (4) @(negedge clk);
    #1 check("final_empty", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
